// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the nibble-serial adder and its slice.
package arith_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice counter width; never below one bit so the counter always exists.
  function automatic int cnt_width(input int nibbles);
    return (nibbles < 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between a requester and the nibble-serial adder.
interface nibble_serial_adder_if
  import arith_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);

endinterface

// File: rtl/cla_add4.sv
// Combinational 4-bit carry-lookahead add slice; exposes c3 for overflow.
module cla_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       c3,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is flattened from g/p terms so no carry depends on another.
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that pushes one nibble per clock through a shared CLA slice.
// state | meaning:  IDLE | waiting for start;  RUN | one slice per edge;  DONE | result committed, done high
module nibble_serial_adder
  import arith_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  nibble_serial_adder_if.slave  bus
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [W-NIBBLE_W-1:0] res_q, res_d;
  logic [W-1:0]        sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_c3;
  logic                slice_cout;
  logic [W-1:0]        res_full;
  logic                accept;

  cla_add4 u_slice (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .c3   (slice_c3),
    .cout (slice_cout)
  );

  // Only the earlier slices are stored; the newest slice completes the word.
  assign res_full = {slice_sum, res_q};
  assign accept   = bus.start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        carry_d = slice_cout;
        res_d   = res_full[W-1:NIBBLE_W];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = res_full;
          cout_d  = slice_cout;
          ovf_d   = slice_c3 ^ slice_cout;
        end
      end
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
